// File: rtl/keypad_pkg.sv
// Shared key codes, state types and digit classification for the keypad entry path.
// KEY_ENTRY_HEX_EN widens the digit class to 0x0-0xD (hex operands).
package keypad_pkg;

   localparam logic [3:0] KEY_CLEAR = 4'hE;
   localparam logic [3:0] KEY_ENTER = 4'hF;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      DONE    = 2'd2
   } entry_state_t;

   typedef enum logic {
      RELEASED = 1'b0,
      HELD     = 1'b1
   } press_state_t;

   function automatic logic is_digit(input logic [3:0] code);
`ifdef KEY_ENTRY_HEX_EN
      return code <= 4'hD;
`else
      return code <= 4'h9;
`endif
   endfunction

endpackage

// File: rtl/key_press_detect.sv
// Turns the column-scanned key_valid/key_code pair into one press_evt per physical press.
//   state    | meaning
//   RELEASED | no key down; next key_valid is a new press
//   HELD     | key down; silence counts idle cycles toward release
module key_press_detect
   import keypad_pkg::*;
#(
   parameter int RELEASE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       press_evt,
   output logic [3:0] press_code
);

   localparam int CW = $clog2(RELEASE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(RELEASE_CYCLES - 1);

   // Release must span a full 4-column scan or a held key would re-trigger.
   if (RELEASE_CYCLES < 4) begin : g_cfg_err
      $error("key_press_detect: RELEASE_CYCLES must be >= 4");
   end

   press_state_t  state, state_next;
   logic [CW-1:0] silence, silence_next;
   logic          evt_next;
   logic [3:0]    code_next;

   always_comb begin
      state_next   = state;
      silence_next = silence;
      evt_next     = 1'b0;
      code_next    = press_code;
      case (state)
         RELEASED: begin
            if (key_valid) begin
               code_next    = key_code;
               evt_next     = 1'b1;
               state_next   = HELD;
               silence_next = '0;
            end
         end
         HELD: begin
            if (key_valid) begin
               silence_next = '0;
            end else if (silence == LAST) begin
               state_next = RELEASED;
            end else begin
               silence_next = silence + CW'(1);
            end
         end
         default: state_next = RELEASED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RELEASED;
         silence    <= '0;
         press_evt  <= 1'b0;
         press_code <= 4'h0;
      end else begin
         state      <= state_next;
         silence    <= silence_next;
         press_evt  <= evt_next;
         press_code <= code_next;
      end
   end

endmodule

// File: rtl/key_entry.sv
// Operand-entry controller: press events build two BCD (or hex with KEY_ENTRY_HEX_EN) operands.
//   state   | meaning
//   ENTER_A | digits edit operand A
//   ENTER_B | A frozen, digits edit operand B
//   DONE    | operands_valid high until ack or CLEAR
module key_entry
   import keypad_pkg::*;
#(
   parameter int DIGITS         = 3,
   parameter int RELEASE_CYCLES = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          key_valid,
   input  logic [3:0]                    key_code,
   output logic [4*DIGITS-1:0]           operand_a,
   output logic [4*DIGITS-1:0]           operand_b,
   output logic                          operands_valid,
   input  logic                          operands_ack,
   output logic [4*DIGITS-1:0]           active_value,
   output logic [$clog2(DIGITS+1)-1:0]   digit_count,
   output logic                          entering_b
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   logic         press_evt;
   logic [3:0]   press_code;

   entry_state_t state, state_next;
   logic [W-1:0] op_a, op_a_next;
   logic [W-1:0] op_b, op_b_next;
   logic [CW-1:0] cnt, cnt_next;
   logic         is_clear, is_enter, digit_ok;

   key_press_detect #(
      .RELEASE_CYCLES(RELEASE_CYCLES)
   ) u_press (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .press_evt (press_evt),
      .press_code(press_code)
   );

   assign is_clear = press_evt && (press_code == KEY_CLEAR);
   assign is_enter = press_evt && (press_code == KEY_ENTER);
   // A full operand silently drops further digits; the count saturates.
   assign digit_ok = press_evt && is_digit(press_code) && (cnt != CW'(DIGITS));

   always_comb begin
      state_next = state;
      op_a_next  = op_a;
      op_b_next  = op_b;
      cnt_next   = cnt;
      case (state)
         ENTER_A: begin
            if (is_clear) begin
               op_a_next = '0;
               cnt_next  = '0;
            end else if (is_enter) begin
               state_next = ENTER_B;
               op_b_next  = '0;
               cnt_next   = '0;
            end else if (digit_ok) begin
               op_a_next = W'({op_a, press_code});
               cnt_next  = cnt + CW'(1);
            end
         end
         ENTER_B: begin
            if (is_clear) begin
               op_b_next = '0;
               cnt_next  = '0;
            end else if (is_enter) begin
               state_next = DONE;
            end else if (digit_ok) begin
               op_b_next = W'({op_b, press_code});
               cnt_next  = cnt + CW'(1);
            end
         end
         DONE: begin
            if (operands_ack || is_clear) begin
               state_next = ENTER_A;
               op_a_next  = '0;
               op_b_next  = '0;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = ENTER_A;
            op_a_next  = '0;
            op_b_next  = '0;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ENTER_A;
         op_a  <= '0;
         op_b  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         op_a  <= op_a_next;
         op_b  <= op_b_next;
         cnt   <= cnt_next;
      end
   end

   assign operand_a      = op_a;
   assign operand_b      = op_b;
   assign operands_valid = (state == DONE);
   assign entering_b     = (state == ENTER_B);
   assign active_value   = (state == ENTER_A) ? op_a : op_b;
   assign digit_count    = cnt;

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed scenarios plus random key streams against a queue-based model.
// Honours KEY_ENTRY_HEX_EN when the design is built with it.
module tb_key_entry;

   localparam int DIGITS = 3;
   localparam int RC     = 8;
   localparam int W      = 4 * DIGITS;
   localparam int CW     = $clog2(DIGITS + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_valid = 1'b0;
   logic [3:0]    key_code = 4'h0;
   logic          operands_ack = 1'b0;
   logic [W-1:0]  operand_a, operand_b, active_value;
   logic          operands_valid, entering_b;
   logic [CW-1:0] digit_count;

   int errors = 0;
   int checks = 0;
   bit rand_ack = 1'b0;

   always #5 clk = ~clk;

   key_entry #(.DIGITS(DIGITS), .RELEASE_CYCLES(RC)) dut (
      .clk           (clk),
      .rst           (rst),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .operands_valid(operands_valid),
      .operands_ack  (operands_ack),
      .active_value  (active_value),
      .digit_count   (digit_count),
      .entering_b    (entering_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_dig(input logic [3:0] c);
`ifdef KEY_ENTRY_HEX_EN
      return c <= 4'hD;
`else
      return c <= 4'h9;
`endif
   endfunction

   function automatic logic [W-1:0] fold(input int q[$]);
      logic [W-1:0] v = '0;
      foreach (q[i]) v = (v << 4) | W'(q[i]);
      return v;
   endfunction

   int         m_phase;  // 0: entering A, 1: entering B, 2: complete
   int         qa[$], qb[$];
   bit         m_pend;
   logic [3:0] m_pcode;
   longint     cyc, last_v;
   bit         have_last;

   always @(posedge clk or posedge rst) begin : model
      int ph;
      if (rst) begin
         m_phase = 0; qa.delete(); qb.delete();
         m_pend = 0; m_pcode = 4'h0; have_last = 0; cyc = 0; last_v = 0;
      end else begin
         ph = m_phase;
         if (m_pend) begin
            if (m_pcode == 4'hE) begin
               if (ph == 0) qa.delete();
               else if (ph == 1) qb.delete();
               else begin m_phase = 0; qa.delete(); qb.delete(); end
            end else if (m_pcode == 4'hF) begin
               if (ph == 0) begin m_phase = 1; qb.delete(); end
               else if (ph == 1) m_phase = 2;
            end else if (is_dig(m_pcode)) begin
               if (ph == 0 && qa.size() < DIGITS) qa.push_back(int'(m_pcode));
               if (ph == 1 && qb.size() < DIGITS) qb.push_back(int'(m_pcode));
            end
         end
         if (ph == 2 && operands_ack) begin m_phase = 0; qa.delete(); qb.delete(); end
         // a press is new only after at least RC idle cycles since the last key_valid
         m_pend = key_valid && (!have_last || (cyc - last_v > RC));
         if (m_pend) m_pcode = key_code;
         if (key_valid) begin last_v = cyc; have_last = 1; end
         cyc++;
      end
   end

   always @(negedge clk) begin : compare
      logic [W-1:0] ea, eb;
      if (!rst) begin
         ea = fold(qa);
         eb = fold(qb);
         chk("operand_a", 32'(operand_a), 32'(ea));
         chk("operand_b", 32'(operand_b), 32'(eb));
         chk("active_value", 32'(active_value), 32'((m_phase == 0) ? ea : eb));
         chk("digit_count", 32'(digit_count), (m_phase == 0) ? qa.size() : qb.size());
         chk("operands_valid", 32'(operands_valid), 32'(m_phase == 2));
         chk("entering_b", 32'(entering_b), 32'(m_phase == 1));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         if (rand_ack) operands_ack = ($urandom_range(0, 15) == 0);
         if (!key_valid) key_code = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic press(input logic [3:0] code, input int bursts);
      for (int i = 0; i < bursts; i++) begin
         key_valid = 1'b1; key_code = code;
         @(negedge clk);
         key_valid = 1'b0;
         step(3);
      end
      step(RC + 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; key_valid = 1'b0; operands_ack = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   function automatic logic [3:0] rand_code();
      int r = $urandom_range(0, 99);
      if (r < 60) return 4'($urandom_range(0, 9));
      if (r < 78) return 4'hF;
      if (r < 84) return 4'hE;
      return 4'($urandom_range(10, 13));
   endfunction

   initial begin
      #1;
      chk("reset_a", 32'(operand_a), 0);
      chk("reset_valid", 32'(operands_valid), 0);
      chk("reset_count", 32'(digit_count), 0);
      step(2);
      rst = 1'b0;
      step(1);

      // single press, 1-in-4 scan for 40 cycles, latency k+2
      key_valid = 1'b1; key_code = 4'h5;
      @(negedge clk);
      key_valid = 1'b0;
      chk("latency_k1", 32'(operand_a), 0);
      @(negedge clk);
      chk("latency_k2", 32'(operand_a), 32'h005);
      step(2);
      for (int i = 0; i < 9; i++) begin
         key_valid = 1'b1; key_code = 4'h5;
         @(negedge clk);
         key_valid = 1'b0;
         step(3);
      end
      step(RC + 2);
      chk("single_a", 32'(operand_a), 32'h005);
      chk("single_count", 32'(digit_count), 1);

      // full entry and handshake
      do_reset();
      press(4'h1, 2); press(4'h2, 1); press(4'h3, 3); press(4'hF, 1);
      press(4'h4, 1); press(4'h5, 2); press(4'hF, 1);
      chk("full_a", 32'(operand_a), 32'h123);
      chk("full_b", 32'(operand_b), 32'h045);
      chk("full_valid", 32'(operands_valid), 1);
      step(5);
      chk("full_valid_held", 32'(operands_valid), 1);
      operands_ack = 1'b1;
      @(negedge clk);
      operands_ack = 1'b0;
      chk("ack_a", 32'(operand_a), 0);
      chk("ack_b", 32'(operand_b), 0);
      chk("ack_valid", 32'(operands_valid), 0);
      chk("ack_entering_b", 32'(entering_b), 0);

      // overflow
      do_reset();
      press(4'h9, 1); press(4'h8, 1); press(4'h7, 1); press(4'h6, 1);
      chk("overflow_a", 32'(operand_a), 32'h987);
      chk("overflow_count", 32'(digit_count), 3);

      // release gap boundary
      do_reset();
      key_valid = 1'b1; key_code = 4'h7; @(negedge clk); key_valid = 1'b0;
      step(RC - 2);
      key_valid = 1'b1; key_code = 4'h7; @(negedge clk); key_valid = 1'b0;
      step(RC + 1);
      key_valid = 1'b1; key_code = 4'h7; @(negedge clk); key_valid = 1'b0;
      step(RC + 2);
      chk("gap_a", 32'(operand_a), 32'h077);
      chk("gap_count", 32'(digit_count), 2);

      // clear and ignored keys
      do_reset();
      press(4'h4, 1); press(4'hE, 1); press(4'hB, 1);
`ifdef KEY_ENTRY_HEX_EN
      chk("hex_b_a", 32'(operand_a), 32'h00B);
      press(4'h2, 1);
      chk("clear_a", 32'(operand_a), 32'h0B2);
`else
      chk("ignored_b_a", 32'(operand_a), 32'h000);
      press(4'h2, 1);
      chk("clear_a", 32'(operand_a), 32'h002);
`endif

      // reset mid-operation, then simultaneous ack and CLEAR
      do_reset();
      press(4'hF, 1); press(4'h1, 1); press(4'h2, 1);
      chk("midrst_b", 32'(operand_b), 32'h012);
      chk("midrst_entering_b", 32'(entering_b), 1);
      key_valid = 1'b1; key_code = 4'h3; @(negedge clk); key_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_a", 32'(operand_a), 0);
      chk("rst_b", 32'(operand_b), 0);
      chk("rst_entering_b", 32'(entering_b), 0);
      chk("rst_count", 32'(digit_count), 0);
      @(negedge clk);
      rst = 1'b0;
      step(1);
      press(4'h3, 3);
      chk("fresh_press_a", 32'(operand_a), 32'h003);
      press(4'hF, 1); press(4'hF, 1);
      chk("done_valid", 32'(operands_valid), 1);
      key_valid = 1'b1; key_code = 4'hE; @(negedge clk);
      key_valid = 1'b0; operands_ack = 1'b1; @(negedge clk);
      operands_ack = 1'b0;
      chk("ackclr_valid", 32'(operands_valid), 0);
      chk("ackclr_a", 32'(operand_a), 0);
      step(RC + 2);
      chk("ackclr_entering_b", 32'(entering_b), 0);
      chk("ackclr_valid_late", 32'(operands_valid), 0);

      // randomized streams, including short gaps and rollover attempts
      do_reset();
      rand_ack = 1'b1;
      for (int n = 0; n < 400; n++) begin
         logic [3:0] c = rand_code();
         int bursts = $urandom_range(1, 4);
         for (int b = 0; b < bursts; b++) begin
            int on = $urandom_range(1, 2);
            for (int j = 0; j < on; j++) begin
               key_valid = 1'b1;
               key_code = ($urandom_range(0, 9) == 0) ? rand_code() : c;
               step(1);
            end
            key_valid = 1'b0;
            step(3);
         end
         step($urandom_range(RC - 4, RC + 3));
      end
      rand_ack = 1'b0;
      operands_ack = 1'b0;
      step(RC + 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_entry.md
# key_entry

Operand-entry controller downstream of the keypad scanner `lecture`. It consumes the per-cycle `key_valid`/`key_code` pair, which is only asserted while the pressed key's column is being scanned. It turns that pair into one event per physical press, with release detection spanning the column scan. Digit events accumulate into two BCD operands, and the block hands them to the arithmetic/display stage through a valid/ack handshake.

## Interface
Parameters:
- `DIGITS`, default 3: maximum digits per operand; operands are 4*DIGITS bits wide.
- `RELEASE_CYCLES`, default 8: consecutive cycles without `key_valid` required to declare a release. Must be ≥ 4, one full column scan; values below 4 are a configuration error.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `key_valid` input 1: key detected in the current scan column, from `lecture`.
- `key_code` input 4: key code 0x0–0xF, meaningful only when `key_valid` is 1.
- `operand_a` output 4*DIGITS: first operand, packed BCD, most recent digit in `[3:0]`.
- `operand_b` output 4*DIGITS: second operand, same format as `operand_a`.
- `operands_valid` output 1: both operands complete; held high until acknowledged.
- `operands_ack` input 1: consumer accepted the operands.
- `active_value` output 4*DIGITS: operand currently being edited, for the display (`operand_b` in ENTER_B and DONE, otherwise `operand_a`).
- `digit_count` output $clog2(DIGITS+1): number of digits held in the active operand.
- `entering_b` output 1: high in state ENTER_B.

## Operation
- **Press detector, states RELEASED and HELD:**
  - In RELEASED, `key_valid`=1 does three things: registers `key_code`, pulses `press_evt` for one cycle, and moves to HELD with the silence counter cleared.
  - In HELD, `key_valid`=1 clears the counter, whatever the code; a second key pressed while one is held produces no event (no rollover).
  - In HELD, `key_valid`=0 increments the counter. When the counter reaches RELEASE_CYCLES-1, the detector returns to RELEASED.
- **Key classes:** 0x0–0x9 are digits. 0xF is ENTER. 0xE is CLEAR. 0xA–0xD are ignored, unless the macro in Configuration is defined.
- **Digit handling:** a digit sets active operand ← {operand[4*DIGITS-5:0], digit} and increments `digit_count`. When `digit_count`==DIGITS, further digits are dropped: no shift, count saturates.
- **Entry FSM, states ENTER_A, ENTER_B and DONE:**
  - ENTER_A: digit events edit A. CLEAR zeroes A and its count. ENTER moves to ENTER_B with B=0 and count=0; A is frozen.
  - ENTER_B: digit events edit B. CLEAR zeroes B only. ENTER moves to DONE.
  - DONE: `operands_valid`=1 and both operands are stable. Digit and ENTER events are ignored. CLEAR moves to ENTER_A with A=B=0 and `operands_valid` dropped. `operands_ack`=1 also moves to ENTER_A with A=B=0.
- **Zero-length operands:** ENTER with zero digits is legal; the operand value is 0.
- **Simultaneous events in DONE:** if `operands_ack` and a CLEAR event arrive in the same cycle, both lead to the same result (ENTER_A, cleared). `operands_ack` outside DONE is ignored.

## Timing
- **Reset values:** every output is 0. The press detector resets to RELEASED and the FSM to ENTER_A.
- **Event latency:**
  - Cycle k: first cycle with `key_valid`=1.
  - Cycle k+1: `press_evt` is high.
  - Cycle k+2: operands, `digit_count` and the state are updated and visible.
- **Handshake timing:** `operands_valid` rises in the cycle after the ENTER event that completes B. It falls in the cycle after the edge that samples `operands_ack`=1.
- **Release timing:** a release is recognised RELEASE_CYCLES cycles after the last `key_valid`=1. A new press is accepted from the following cycle onward.
- **Reset mid-operation:** asynchronous assertion clears everything immediately. Any press still held after reset is treated as a new press at the first `key_valid`=1.

## Configuration
- `KEY_ENTRY_HEX_EN`: when defined, codes 0xA–0xD are accepted as digits and the operands are hex nibbles. 0xE and 0xF remain CLEAR and ENTER.
- When the macro is undefined, 0xA–0xD produce a `press_evt` but no state or operand change, and the operands are strictly BCD.

## Structure
- **Package `keypad_pkg`:**
  - `KEY_CLEAR` = 4'hE and `KEY_ENTER` = 4'hF.
  - `entry_state_t`, with values ENTER_A, ENTER_B and DONE.
  - `press_state_t`, with values RELEASED and HELD.
- **Sub-module `key_press_detect`** (parameter RELEASE_CYCLES):
  - Inputs: `key_valid` and `key_code`.
  - Outputs: `press_evt` and `press_code`.
- **Top:** `key_entry` instantiates `key_press_detect` and contains the entry FSM and the operand registers.

## Test plan
- **Single press:** hold key 0x5 with `key_valid` high 1 cycle in 4 for 40 cycles, then release → exactly one event; `operand_a`=0x005 and `digit_count`=1, visible at cycle k+2.
- **Full entry:** press 1,2,3,ENTER,4,5,ENTER, each press separated by ≥ RELEASE_CYCLES idle cycles → `operand_a`=0x123, `operand_b`=0x045, and `operands_valid`=1 held until `operands_ack` is pulsed. The next cycle shows A=B=0 and state ENTER_A.
- **Overflow:** press 9,8,7,6 → `operand_a`=0x987 and `digit_count`=3; the fourth digit is dropped.
- **Gap shorter than release time:** a gap of RELEASE_CYCLES-2 idle cycles between two `key_valid` bursts of key 7 → one event only. A gap of RELEASE_CYCLES+1 cycles → two events, giving 0x077.
- **Clear and ignored keys:** press 4, CLEAR, 0xB, 2 → `operand_a`=0x002 without the macro. With `KEY_ENTRY_HEX_EN` the result is 0x00B then 0x0B2.
- **Reset mid-operation:** `rst` pulsed while in ENTER_B with B=0x012 → all outputs 0 immediately. A held key then yields a fresh event, and DONE with simultaneous `operands_ack` and CLEAR lands in a single ENTER_A.
